fpu_addsub_hs: RTL
==================

// Module: fpu_addsub_hs
// PURPOSE
//  Parametrised floating-point add/subtract unit for the team's custom {sign, exp, mantissa} format.
//  Multi-cycle FSM with ready/valid handshakes on input and output, guard/round/sticky bits, and
//  round-to-nearest-even. Produces a 4-bit status word. Sits between the operand register file and the result bus.
// PARAMETERS
//  EXP_W   6    exponent field width; BIAS = 2**(EXP_W-1)-1 (31 at default)
//  MAN_W   25   stored mantissa width; hidden 1 is implicit; word width W = 1+EXP_W+MAN_W
// PORTS
//  clock      in   1   clock
//  reset      in   1   asynchronous, active-low reset
//  in_valid   in   1   operands and op_sub are valid
//  in_ready   out  1   unit idle; accepts operands (combinational: state==IDLE)
//  op_a       in   W   operand A
//  op_b       in   W   operand B
//  op_sub     in   1   0: A+B, 1: A-B (inverts sign of B)
//  out_valid  out  1   data_out/status_out hold a result
//  out_ready  in   1   consumer accepts the result
//  data_out   out  W   result word
//  status_out out  4   {INEXACT, UNDERFLOW, OVERFLOW, ZERO}
// BEHAVIOUR
//  - Reset (async): state=IDLE, data_out=0, status_out=0, out_valid=0. Reset mid-operation discards the operation.
//  - Format: exp field 0 means zero (mantissa ignored, no denormals). Fields 1..2**EXP_W-1 are normal. No inf/NaN.
//  - Handshake: accept on the edge where in_valid&&in_ready; op_a, op_b, op_sub are registered there.
//    out_valid stays high with data_out and status_out stable until the edge where out_valid&&out_ready, then IDLE.
//  - FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE. One cycle per state except DONE (waits on out_ready).
//    out_valid rises 4 edges after the accept edge. in_ready is high again the cycle after the result handshake.
//  - ALIGN: the larger-exponent operand is the reference. Shift the other {1,man,G,R,S} right by the exponent
//    difference; shifted-out bits OR into S. If the difference is >= MAN_W+3, that operand reduces to S only.
//    A zero operand contributes 0.
//  - ADD: same effective sign -> magnitude add into a MAN_W+5-bit sum (carry bit).
//    Otherwise subtract smaller from larger; the sign of the larger wins. Exact cancellation -> +0.
//  - NORM, single cycle using fpu_lzc:
//    - Carry set: shift right 1 (LSB ORs into S), exp+1.
//    - Otherwise: shift left by the leading-zero count, exp minus that count.
//    - Exponent is held signed in EXP_W+2 bits.
//  - ROUND: RNE. Increment if G && (R||S||lsb). A mantissa carry-out renormalises (exp+1).
//    INEXACT = G|R|S before rounding.
//  - Result rules:
//    - exp > 2**EXP_W-1: saturate to {sign, all-ones exp, all-ones man}; OVERFLOW=1, INEXACT=1.
//    - exp < 1: signed zero; UNDERFLOW=1, INEXACT=1, ZERO=1.
//    - Zero result: exp=0, man=0, ZERO=1.
//  - Simultaneous in_valid during DONE is ignored (in_ready=0). No back-to-back overlap.
// STRUCTURE
//  - fpu_pkg: state_t enum (IDLE, ALIGN, ADD, NORM, ROUND, DONE), STAT_ZERO/OVF/UNF/INX bit indices,
//    and a function bias(EXP_W).
//  - Sub-module fpu_lzc #(WIDTH): combinational leading-zero count for normalisation.
//  - FSM and datapath registers live in this module.
// TESTING (default EXP_W=6, MAN_W=25)
//  - 1.0+1.0: op_a=op_b=32'h3E000000, op_sub=0 -> data_out=32'h40000000, status=4'b0000, out_valid 4 cycles after accept.
//  - 3.0-1.0: op_a=32'h41000000, op_b=32'h3E000000, op_sub=1 -> 32'h40000000, status=4'b0000.
//  - 1.0-1.0 -> 32'h00000000, status=4'b0001 (ZERO).
//  - Tie to even: 1.0 + 2^-26 (op_b=32'h0A000000) -> 32'h3E000000, status=4'b1000.
//  - Overflow: 32'h7FFFFFFF+32'h7FFFFFFF -> 32'h7FFFFFFF, status=4'b1010.
//  - Backpressure/reset: hold out_ready=0 for 3 cycles -> data stable, in_ready=0.
//    Pull reset low during NORM -> out_valid=0, in_ready=1 after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the custom {sign, exp, mantissa} floating-point units.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int STAT_ZERO = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_UNF  = 2;
  localparam int STAT_INX  = 3;

  function automatic int bias(input int exp_w);
    return (2 ** (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc
  import fpu_pkg::*;
#(
  parameter int WIDTH = 29
) (
  input  logic [WIDTH-1:0]               value,
  output logic [$clog2(WIDTH+1)-1:0]     count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Scan upward so the most significant set bit determines the count.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        count = CW'(WIDTH - 1 - i);
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_hs.sv
// Multi-cycle floating-point add/subtract with ready/valid handshakes and round-to-nearest-even.
module fpu_addsub_hs
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 6,
  parameter  int MAN_W = 25,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);

  // Extended mantissa is {hidden, man, G, R, S}; the sum adds one carry bit on top.
  localparam int XW  = MAN_W + 4;
  localparam int SW  = MAN_W + 5;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(XW + 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** EXP_W) - 1);

  state_t state_r, state_s;

  logic [W-1:0]           a_r, b_r;
  logic                   sub_r;
  logic [XW-1:0]          big_r, small_r;
  logic                   big_sign_r, small_sign_r;
  logic signed [EW-1:0]   exp_r;
  logic [SW-1:0]          sum_r;
  logic                   sign_r;
  logic [XW-1:0]          norm_r;
  logic                   zero_r;

  logic [EXP_W-1:0]       a_exp_s, b_exp_s, ref_exp_s, oth_exp_s, diff_s;
  logic [XW-1:0]          a_ext_s, b_ext_s, ref_ext_s, oth_ext_s, shifted_s, mask_s;
  logic                   b_sign_s, ref_sign_s, oth_sign_s, lost_s;
  logic [SW-1:0]          add_sum_s;
  logic                   add_sign_s;
  logic [LZW-1:0]         lz_s;
  logic [XW-1:0]          norm_s;
  logic signed [EW-1:0]   norm_exp_s;
  logic                   zero_s;
  logic                   inexact_s, inc_s;
  logic [MAN_W+1:0]       mant_s;
  logic [MAN_W-1:0]       man_s;
  logic signed [EW-1:0]   rexp_s;
  logic [W-1:0]           res_s;
  logic [3:0]             stat_s;

  assign in_ready = (state_r == IDLE);

  // Choose the larger-exponent operand as reference and align the other with sticky collection.
  always_comb begin
    a_exp_s  = a_r[W-2 -: EXP_W];
    b_exp_s  = b_r[W-2 -: EXP_W];
    a_ext_s  = (a_exp_s == '0) ? '0 : {1'b1, a_r[MAN_W-1:0], 3'b000};
    b_ext_s  = (b_exp_s == '0) ? '0 : {1'b1, b_r[MAN_W-1:0], 3'b000};
    b_sign_s = b_r[W-1] ^ sub_r;
    if (b_exp_s > a_exp_s) begin
      ref_exp_s  = b_exp_s;
      oth_exp_s  = a_exp_s;
      ref_ext_s  = b_ext_s;
      oth_ext_s  = a_ext_s;
      ref_sign_s = b_sign_s;
      oth_sign_s = a_r[W-1];
    end else begin
      ref_exp_s  = a_exp_s;
      oth_exp_s  = b_exp_s;
      ref_ext_s  = a_ext_s;
      oth_ext_s  = b_ext_s;
      ref_sign_s = a_r[W-1];
      oth_sign_s = b_sign_s;
    end
    diff_s    = ref_exp_s - oth_exp_s;
    shifted_s = '0;
    mask_s    = '0;
    lost_s    = 1'b0;
    if (int'(diff_s) >= MAN_W + 3) begin
      shifted_s = {{(XW-1){1'b0}}, |oth_ext_s};
    end else begin
      mask_s       = ~({XW{1'b1}} << diff_s);
      lost_s       = |(oth_ext_s & mask_s);
      shifted_s    = oth_ext_s >> diff_s;
      shifted_s[0] = shifted_s[0] | lost_s;
    end
  end

  // Signed-magnitude add; an exact cancellation always yields +0.
  always_comb begin
    if (big_sign_r == small_sign_r) begin
      add_sum_s  = {1'b0, big_r} + {1'b0, small_r};
      add_sign_s = big_sign_r;
    end else if (big_r >= small_r) begin
      add_sum_s  = {1'b0, big_r - small_r};
      add_sign_s = big_sign_r;
    end else begin
      add_sum_s  = {1'b0, small_r - big_r};
      add_sign_s = small_sign_r;
    end
    if (add_sum_s == '0) begin
      add_sign_s = 1'b0;
    end else begin
      add_sign_s = add_sign_s;
    end
  end

  fpu_lzc #(.WIDTH(XW)) u_lzc (
    .value (sum_r[XW-1:0]),
    .count (lz_s)
  );

  // Normalise: a carry shifts right once, otherwise shift left by the leading-zero count.
  always_comb begin
    zero_s = (sum_r == '0);
    if (sum_r[SW-1]) begin
      norm_s     = sum_r[SW-1:1];
      norm_s[0]  = sum_r[1] | sum_r[0];
      norm_exp_s = exp_r + EXP_ONE;
    end else begin
      norm_s     = sum_r[XW-1:0] << lz_s;
      norm_exp_s = exp_r - $signed({{(EW-LZW){1'b0}}, lz_s});
    end
  end

  // Round to nearest even, then apply saturation, underflow and zero rules.
  always_comb begin
    inexact_s = norm_r[2] | norm_r[1] | norm_r[0];
    inc_s     = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
    mant_s    = {1'b0, norm_r[XW-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
    if (mant_s[MAN_W+1]) begin
      man_s  = mant_s[MAN_W:1];
      rexp_s = exp_r + EXP_ONE;
    end else begin
      man_s  = mant_s[MAN_W-1:0];
      rexp_s = exp_r;
    end
    stat_s = 4'b0000;
    if (zero_r) begin
      res_s             = '0;
      stat_s[STAT_ZERO] = 1'b1;
    end else if (rexp_s > EXP_MAX) begin
      res_s             = {sign_r, {(W-1){1'b1}}};
      stat_s[STAT_OVF]  = 1'b1;
      stat_s[STAT_INX]  = 1'b1;
    end else if (rexp_s < EXP_ONE) begin
      res_s             = {sign_r, {(W-1){1'b0}}};
      stat_s[STAT_UNF]  = 1'b1;
      stat_s[STAT_INX]  = 1'b1;
      stat_s[STAT_ZERO] = 1'b1;
    end else begin
      res_s             = {sign_r, rexp_s[EXP_W-1:0], man_s};
      stat_s[STAT_INX]  = inexact_s;
    end
  end

  // Next-state logic: one cycle per stage, DONE waits for the consumer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = ALIGN;
        end else begin
          state_s = IDLE;
        end
      end
      ALIGN:   state_s = ADD;
      ADD:     state_s = NORM;
      NORM:    state_s = ROUND;
      ROUND:   state_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pipeline-stage registers and the held result, each loaded in its own state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_r          <= '0;
      b_r          <= '0;
      sub_r        <= 1'b0;
      big_r        <= '0;
      small_r      <= '0;
      big_sign_r   <= 1'b0;
      small_sign_r <= 1'b0;
      exp_r        <= '0;
      sum_r        <= '0;
      sign_r       <= 1'b0;
      norm_r       <= '0;
      zero_r       <= 1'b0;
      data_out     <= '0;
      status_out   <= 4'b0000;
      out_valid    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r   <= op_a;
            b_r   <= op_b;
            sub_r <= op_sub;
          end
        end
        ALIGN: begin
          big_r        <= ref_ext_s;
          small_r      <= shifted_s;
          big_sign_r   <= ref_sign_s;
          small_sign_r <= oth_sign_s;
          exp_r        <= $signed({2'b00, ref_exp_s});
        end
        ADD: begin
          sum_r  <= add_sum_s;
          sign_r <= add_sign_s;
        end
        NORM: begin
          norm_r <= norm_s;
          exp_r  <= norm_exp_s;
          zero_r <= zero_s;
        end
        ROUND: begin
          data_out   <= res_s;
          status_out <= stat_s;
          out_valid  <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
